// File: rtl/upm_thermal_chain_ctrl.sv
// Sequencer for the thermal CBB configuration chain: one request becomes a sel/capture/shift/update access.
// Optional write read-back verify pass is enabled by defining UPM_THERMAL_CHAIN_CTRL_VERIFY_EN.
module upm_thermal_chain_ctrl #(
  parameter int NUM_THERMAL_CBB = 1,
  parameter int BITS_PER_CBB    = 16,
  localparam int CHAIN_LEN      = NUM_THERMAL_CBB * BITS_PER_CBB
) (
  input  logic                 tck,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [CHAIN_LEN-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 sel,
  output logic                 capture,
  output logic                 shift,
  output logic                 update,
  output logic                 si,
  input  logic                 so,
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
  output logic                 verify_fail,
`endif
  input  logic                 power_enable_error_next
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEL      = 3'd1;
  localparam logic [2:0] CAPTURE  = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] UPDATE   = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
  localparam logic [2:0] VCAPTURE = 3'd6;
  localparam logic [2:0] VSHIFT   = 3'd7;
`endif

  logic [2:0]           state_q, state_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d, rdata_q, so_vec, sr_rot;
  logic [CW-1:0]        count_q;
  logic                 write_q, err_q, abort, last, accept;
  logic                 req_ready_q, rsp_valid_q, busy_q, sel_q, capture_q, shift_q, update_q, si_q;
  logic                 sel_d, capture_d, shift_d, update_d;

  // The write data rotates rather than shifts so the verify pass can compare against it again.
  assign sr_rot = (sr_q >> 1) | (sr_q << (CHAIN_LEN - 1));
  assign so_vec = CHAIN_LEN'(so);
  assign last   = (count_q == LAST);
  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SEL;
        sr_d    = req_wdata;
      end
      SEL: begin
        abort   = power_enable_error_next;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        abort   = power_enable_error_next;
        state_d = SHIFT;
      end
      SHIFT: begin
        abort = power_enable_error_next;
        sr_d  = sr_rot;
        if (last) state_d = write_q ? UPDATE : DONE;
      end
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
      UPDATE: state_d = VCAPTURE;
      VCAPTURE: begin
        abort   = power_enable_error_next;
        state_d = VSHIFT;
      end
      VSHIFT: begin
        abort = power_enable_error_next;
        sr_d  = sr_rot;
        if (last) state_d = DONE;
      end
`else
      UPDATE: state_d = DONE;
`endif
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = DONE;
  end

  always_comb begin
    sel_d     = 1'b0;
    capture_d = 1'b0;
    shift_d   = 1'b0;
    update_d  = 1'b0;
    case (state_d)
      SEL:     sel_d = 1'b1;
      CAPTURE: begin sel_d = 1'b1; capture_d = 1'b1; end
      SHIFT:   begin sel_d = 1'b1; shift_d   = 1'b1; end
      UPDATE:  begin sel_d = 1'b1; update_d  = 1'b1; end
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
      VCAPTURE: begin sel_d = 1'b1; capture_d = 1'b1; end
      VSHIFT:   begin sel_d = 1'b1; shift_d   = 1'b1; end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge tck) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      count_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sel_q       <= 1'b0;
      capture_q   <= 1'b0;
      shift_q     <= 1'b0;
      update_q    <= 1'b0;
      si_q        <= 1'b0;
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
      verify_fail <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      sel_q       <= sel_d;
      capture_q   <= capture_d;
      shift_q     <= shift_d;
      update_q    <= update_d;
      si_q        <= (state_d == SHIFT) ? sr_d[0] : 1'b0;

      if (accept) begin
        write_q <= req_write;
        count_q <= '0;
        rdata_q <= '0;
        err_q   <= 1'b0;
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
        verify_fail <= 1'b0;
`endif
      end

      // An aborting cycle's so bit is discarded; only earlier bits are kept.
      if (abort) begin
        err_q <= 1'b1;
      end else if (state_q == SHIFT) begin
        rdata_q <= rdata_q | (so_vec << count_q);
        if (!last) count_q <= count_q + 1'b1;
      end
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
      else if (state_q == VCAPTURE) begin
        count_q <= '0;
      end else if (state_q == VSHIFT) begin
        if (so != sr_q[0]) verify_fail <= 1'b1;
        if (!last) count_q <= count_q + 1'b1;
      end
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign sel       = sel_q;
  assign capture   = capture_q;
  assign shift     = shift_q;
  assign update    = update_q;
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
  // During read-back the chain output is fed straight back so its contents survive the pass.
  assign si = (state_q == VSHIFT) ? so : si_q;
`else
  assign si = si_q;
`endif

endmodule

// File: tb/tb_upm_thermal_chain_ctrl.sv
// Self-checking bench for upm_thermal_chain_ctrl with a behavioural chain model (2 CBBs x 16 bits).
// Covers reset, write/read, error abort, backpressure, randomized accesses and the verify option when built in.
module tb_upm_thermal_chain_ctrl;
  localparam int CL     = 32;
  localparam int RD_LAT = CL + 2;
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
  localparam int WR_LAT = 2 * CL + 4;
`else
  localparam int WR_LAT = CL + 3;
`endif

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic busy, sel, capture, shift, update, si, so, power_enable_error_next;
  logic [CL-1:0] req_wdata, rsp_rdata;
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
  logic verify_fail;
`endif

  always #5 clk = ~clk;

  upm_thermal_chain_ctrl #(.NUM_THERMAL_CBB(2), .BITS_PER_CBB(16)) dut (
    .tck(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .sel(sel), .capture(capture), .shift(shift), .update(update), .si(si), .so(so),
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
    .verify_fail(verify_fail),
`endif
    .power_enable_error_next(power_enable_error_next)
  );

  // Chain model: a plain shift register, bit 0 nearest so; capture applies the stuck-bit mask.
  logic [CL-1:0] chain      = '0;
  logic [CL-1:0] si_word    = '0;
  logic [CL-1:0] stuck_mask = '0;
  int upd_cnt = 0, vld_cnt = 0, viol = 0;
  assign so = chain[0];

  always @(posedge clk) begin
    if (capture) chain <= chain & ~stuck_mask;
    else if (shift) begin
      chain   <= {si, chain[CL-1:1]};
      si_word <= {si, si_word[CL-1:1]};
    end
    if (update) upd_cnt <= upd_cnt + 1;
    if (rsp_valid) vld_cnt <= vld_cnt + 1;
    if ((int'(capture) + int'(shift) + int'(update) > 1) || (!sel && (capture || shift || update)))
      viol <= viol + 1;
  end

  int checks = 0, errors = 0;
  logic [CL-1:0] exp_rd;
  int u0, v0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("ready_wait", req_ready, 1);
  endtask

  // Called at a negedge; returns 1ns after the acceptance edge.
  task automatic issue(input logic wr, input logic [CL-1:0] wd, input logic err_idle);
    wait_ready();
    exp_rd = chain & ~stuck_mask;
    u0 = upd_cnt;
    req_valid = 1'b1; req_write = wr; req_wdata = wd; power_enable_error_next = err_idle;
    @(posedge clk); #1;
    req_valid = 1'b0; power_enable_error_next = 1'b0;
    check("accepted", {busy, req_ready}, 2'b10);
  endtask

  task automatic wait_rsp(input int exp_lat, input string tag);
    int lat = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic finish_rsp(input int hold, input logic [CL-1:0] exp_data, input logic exp_err,
                            input string tag);
    check({tag, "_rdata"}, rsp_rdata, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {rsp_valid, req_ready, rsp_rdata}, {1'b1, 1'b0, exp_data});
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check({tag, "_release"}, {rsp_valid, req_ready, busy}, 3'b010);
    @(negedge clk);
  endtask

  task automatic run_op(input logic wr, input logic [CL-1:0] wd, input int hold,
                        input logic err_idle, input string tag);
    logic [CL-1:0] exp_chain;
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
    exp_chain = wd & ~stuck_mask;
`else
    exp_chain = wd;
`endif
    issue(wr, wd, err_idle);
    wait_rsp(wr ? WR_LAT : RD_LAT, tag);
`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
    check({tag, "_vfail"}, verify_fail, wr && ((wd & stuck_mask) != '0));
`endif
    finish_rsp(hold, exp_rd, 1'b0, tag);
    check({tag, "_updates"}, upd_cnt - u0, wr ? 1 : 0);
    check({tag, "_si_seq"}, si_word, exp_chain);
    check({tag, "_chain"}, chain, exp_chain);
  endtask

  initial begin
    logic [CL-1:0] w;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; power_enable_error_next = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_ctrl", {req_ready, rsp_valid, busy, sel, capture, shift, update, si}, 8'b1000_0000);
    check("rst_rsp", {rsp_err, rsp_rdata}, '0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);

    // Preload, then the directed write
    run_op(1'b1, 32'h1234_5678, 0, 1'b0, "preload");
    run_op(1'b1, 32'hA5C3_0F1E, 2, 1'b0, "write");
    run_op(1'b0, 32'h0000_0000, 1, 1'b0, "read");

    // Backpressure with a queued request that must wait for the handshake
    w = 32'h0F0F_3C3C;
    issue(1'b0, 32'hDEAD_BEEF, 1'b0);
    wait_rsp(RD_LAT, "bp");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_wdata = w;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, req_ready, busy, rsp_rdata}, {3'b101, exp_rd});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check("bp_no_bypass", {rsp_valid, req_ready, busy}, 3'b010);
    exp_rd = chain & ~stuck_mask;
    @(posedge clk); #1; req_valid = 1'b0;
    check("bp_next_accept", {req_ready, busy}, 2'b01);
    u0 = upd_cnt;
    wait_rsp(WR_LAT, "bp_wr");
    finish_rsp(0, exp_rd, 1'b0, "bp_wr");
    check("bp_wr_chain", chain, w);

    // Error abort at shift count 5
    issue(1'b1, 32'h5555_AAAA, 1'b0);
    repeat (7) @(posedge clk);
    #1; power_enable_error_next = 1'b1;
    @(posedge clk); #1; power_enable_error_next = 1'b0;
    check("abort_valid", rsp_valid, 1);
    finish_rsp(1, exp_rd & 32'h0000_001F, 1'b1, "abort");
    check("abort_updates", upd_cnt - u0, 0);

    // Reset mid-shift at count 10
    issue(1'b1, 32'hCAFE_F00D, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_in_shift", shift, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctrl", {req_ready, rsp_valid, busy, sel, capture, shift, update}, 7'b1000000);
    @(posedge clk); #1; reset = 1'b0;
    v0 = vld_cnt;
    repeat (50) @(posedge clk);
    check("midrst_updates", upd_cnt - u0, 0);
    check("midrst_no_rsp", vld_cnt - v0, 0);
    @(negedge clk);

    // Randomized accesses against the chain model
    for (int i = 0; i < 8; i++) begin
      run_op(1'($urandom_range(0, 1)), CL'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), "rand");
    end

`ifdef UPM_THERMAL_CHAIN_CTRL_VERIFY_EN
    stuck_mask[17] = 1'b1;
    run_op(1'b1, 32'hFFFF_FFFF, 0, 1'b0, "vfy_stuck");
    stuck_mask = '0;
    run_op(1'b1, 32'h1357_9BDF, 0, 1'b0, "vfy_clean");
`endif

    check("strobe_exclusive", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upm_thermal_chain_ctrl.md
Name: upm_thermal_chain_ctrl

Overview:
- Sequencer for the daisy-chained thermal CBB configuration chain.
- Converts a parallel read/write request into a one-shot sel/capture/shift/update access on the chain.
- Returns the captured chain contents on a valid/ready response channel.
- Sits between the UPM TAP/firmware request path and the thermal CBB wrapper top. Runs in the tck domain.

Parameters:
- NUM_THERMAL_CBB, 1, number of thermal CBBs on the chain (>=1).
- BITS_PER_CBB, 16, scan bits contributed by each CBB.
- CHAIN_LEN, NUM_THERMAL_CBB*BITS_PER_CBB, derived; total chain length; not to be overridden.

Ports:
- tck  in  1  block clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (IDLE only).
- req_write  in  1  1 = capture+shift+update; 0 = capture+shift only (no update).
- req_wdata  in  CHAIN_LEN  data shifted in; bit 0 shifted first.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  CHAIN_LEN  captured chain data; bit 0 = first bit out.
- rsp_err  out  1  access aborted by power-enable error.
- busy  out  1  high in every state except IDLE.
- sel  out  1  chain select.
- capture  out  1  capture strobe.
- shift  out  1  shift enable.
- update  out  1  update strobe.
- si  out  1  serial data into chain.
- so  in  1  serial data from chain.
- power_enable_error_next  in  1  error from last CBB of chain.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. All outputs are 0 on the cycle after reset is sampled, except req_ready, which is 1. rsp_rdata clears to 0.
- Reset mid-operation: the access is abandoned immediately. No update pulse and no response are produced.
- States: IDLE, SEL, CAPTURE, SHIFT, UPDATE, DONE. All outputs are registered.
- IDLE:
  - req_ready=1.
  - Accept when req_valid&req_ready. On acceptance, latch req_write and req_wdata into a shift register, clear the bit counter, then go to SEL.
- SEL: sel=1 for 1 cycle, then CAPTURE.
- CAPTURE: sel=1, capture=1 for 1 cycle, then SHIFT.
- SHIFT:
  - sel=1, shift=1 for exactly CHAIN_LEN cycles.
  - si = wdata shift register bit 0. Each cycle the register shifts right.
  - so is sampled in the same cycle into rdata[count]. count increments 0..CHAIN_LEN-1.
  - At count==CHAIN_LEN-1, go to UPDATE if write, else DONE.
- UPDATE: sel=1, update=1 for 1 cycle, then DONE.
- DONE:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready is sampled high.
  - Then return to IDLE. The next request can be accepted 1 cycle later (no IDLE bypass).
  - sel=0 in DONE.
- Latency from acceptance edge to rsp_valid rising:
  - write: CHAIN_LEN+3 cycles.
  - read: CHAIN_LEN+2 cycles.
- Strobes are mutually exclusive. capture, shift and update are never high together. sel is high in SEL through UPDATE only.
- Error abort:
  - Trigger: power_enable_error_next sampled high in any of SEL, CAPTURE or SHIFT.
  - Next state is DONE with rsp_err=1 and no update pulse. rsp_rdata holds the bits captured so far; remaining bits are 0.
  - Error during UPDATE is ignored; the update has already been issued.
  - Error while in IDLE does not block acceptance.
- Counter width: $clog2(CHAIN_LEN+1). The counter never wraps.
- CHAIN_LEN==1: SHIFT lasts exactly 1 cycle.
- rsp_ready high while rsp_valid is low has no effect.

Optional Feature:
- UPM_THERMAL_CHAIN_CTRL_VERIFY_EN, for write requests only.
- Defined:
  - After UPDATE, a second pass is inserted: VCAPTURE (capture=1), then VSHIFT (CHAIN_LEN cycles, si = recirculated so).
  - Captured data is compared against the latched req_wdata. Output verify_fail (1 bit, reset 0) is valid with rsp_valid.
  - Write latency becomes 2*CHAIN_LEN+4.
  - The error abort also applies during VCAPTURE and VSHIFT.
- Undefined: no extra states, no verify_fail port. Latency is as above.

Test Plan:
Configuration for all scenarios: NUM_THERMAL_CBB=2, BITS_PER_CBB=16 (CHAIN_LEN=32).
1. Reset: reset=1 for 2 cycles mid-SHIFT (count=10) -> next cycle all strobes 0, req_ready=1, rsp_valid=0, and no update pulse ever appears.
2. Write: req_wdata=32'hA5C3_0F1E with a chain model preloaded with 32'h1234_5678 -> si sequence = wdata LSB-first; rsp_rdata=32'h1234_5678; exactly one update pulse; rsp_valid at acceptance+35; chain now holds A5C30F1E.
3. Read: req_write=0 -> 32 shift cycles, no update pulse; rsp_valid at acceptance+34; rdata equals the chain contents.
4. Error abort: assert power_enable_error_next at shift count 5 -> rsp_err=1, rdata[31:5]=0, no update.
5. Backpressure: rsp_ready=0 for 7 cycles -> rsp_valid and rsp_rdata stable; req_ready=0; a new req_valid is not accepted until the cycle after the handshake.
6. With VERIFY_EN: chain model forces one stuck bit (bit 17=0), write 32'hFFFF_FFFF -> verify_fail=1 at acceptance+68.
